// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and pipeline-control unit for the five-stage core.
//   - Forwards register operands into execute (M result preferred over W).
//   - Generates per-stage STALL / FLUSH / CONTINUE for data-memory wait,
//     taken branch, load-use, multi-cycle scoreboard hit and multi-cycle
//     capacity hazards.
//   - Tracks destinations of in-flight multi-cycle (MUL/DIV) operations in a
//     pending-register scoreboard and counts outstanding operations.
//   - Counts cycles with any stall asserted (saturating).
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   rs1_d_i, rs2_d_i, mc_d_i       decode sources, decode is multi-cycle op
//   rs1_e_i, rs2_e_i, rd_e_i       execute sources / destination
//   result_src_e_i                 execute instruction is a load
//   mc_issue_e_i                   multi-cycle op leaves execute this cycle
//   pc_src_e_i                     taken branch/jump resolved in execute
//   rd_m_i, rd_w_i                 memory / writeback destinations
//   reg_write_m_i, reg_write_w_i   memory / writeback write enables
//   mem_busy_i                     data memory not ready
//   mc_done_i, mc_rd_i             multi-cycle unit retires to mc_rd_i
//   forward_a_e_o, forward_b_e_o   00 reg file, 01 W, 10 M
//   control_[fdemw]_o              per-stage pipeline control
//   stall_cnt_o                    saturating count of stall cycles
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;
  typedef enum logic [1:0] {
    CTRL_CONTINUE = 2'b00,
    CTRL_STALL    = 2'b01,
    CTRL_FLUSH    = 2'b10
  } pipeline_control;
endpackage

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int MC_DEPTH   = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] rs1_d_i,
  input  logic [ADDR_WIDTH-1:0] rs2_d_i,
  input  logic                  mc_d_i,
  input  logic [ADDR_WIDTH-1:0] rs1_e_i,
  input  logic [ADDR_WIDTH-1:0] rs2_e_i,
  input  logic [ADDR_WIDTH-1:0] rd_e_i,
  input  logic                  result_src_e_i,
  input  logic                  mc_issue_e_i,
  input  logic                  pc_src_e_i,
  input  logic [ADDR_WIDTH-1:0] rd_m_i,
  input  logic [ADDR_WIDTH-1:0] rd_w_i,
  input  logic                  reg_write_m_i,
  input  logic                  reg_write_w_i,
  input  logic                  mem_busy_i,
  input  logic                  mc_done_i,
  input  logic [ADDR_WIDTH-1:0] mc_rd_i,
  output logic [1:0]            forward_a_e_o,
  output logic [1:0]            forward_b_e_o,
  output pipeline_control       control_f_o,
  output pipeline_control       control_d_o,
  output pipeline_control       control_e_o,
  output pipeline_control       control_m_o,
  output pipeline_control       control_w_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

  localparam int              NREG   = 2 ** ADDR_WIDTH;
  localparam logic [2:0]      MC_MAX = 3'(MC_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = {ADDR_WIDTH{1'b0}};

  logic [NREG-1:0]      r_pending;
  logic [2:0]           r_outstanding;
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  logic [NREG-1:0] w_pending_nxt;
  logic [3:0]      w_inflight_sum;
  logic            w_load_use;
  logic            w_sb_hit;
  logic            w_mc_full;
  logic            w_d_stall;
  logic            w_done_acc;
  logic            w_issue_acc;
  logic            w_stall_any;

  // Operand forwarding: newest producer (M) wins over the older one (W).
  always_comb begin
    forward_a_e_o = 2'b00;
    forward_b_e_o = 2'b00;
    if (rs1_e_i != ZERO_REG && reg_write_m_i && rs1_e_i == rd_m_i) begin
      forward_a_e_o = 2'b10;
    end else if (rs1_e_i != ZERO_REG && reg_write_w_i && rs1_e_i == rd_w_i) begin
      forward_a_e_o = 2'b01;
    end else begin
      forward_a_e_o = 2'b00;
    end
    if (rs2_e_i != ZERO_REG && reg_write_m_i && rs2_e_i == rd_m_i) begin
      forward_b_e_o = 2'b10;
    end else if (rs2_e_i != ZERO_REG && reg_write_w_i && rs2_e_i == rd_w_i) begin
      forward_b_e_o = 2'b01;
    end else begin
      forward_b_e_o = 2'b00;
    end
  end

  // Decode hazard terms. The capacity check counts an op leaving E this
  // cycle as already in flight so decode cannot overshoot MC_DEPTH.
  always_comb begin
    w_load_use     = result_src_e_i && (rd_e_i != ZERO_REG) &&
                     ((rs1_d_i == rd_e_i) || (rs2_d_i == rd_e_i));
    w_sb_hit       = r_pending[rs1_d_i] | r_pending[rs2_d_i];
    w_inflight_sum = {1'b0, r_outstanding} + {3'b000, mc_issue_e_i};
    w_mc_full      = mc_d_i && (w_inflight_sum >= {1'b0, MC_MAX});
    w_d_stall      = w_load_use | w_sb_hit | w_mc_full;
    w_stall_any    = mem_busy_i | (w_d_stall & ~pc_src_e_i);
  end

  // Stage control, highest-priority hazard first.
  always_comb begin
    control_f_o = CTRL_CONTINUE;
    control_d_o = CTRL_CONTINUE;
    control_e_o = CTRL_CONTINUE;
    control_m_o = CTRL_CONTINUE;
    control_w_o = CTRL_CONTINUE;
    if (mem_busy_i) begin
      control_f_o = CTRL_STALL;
      control_d_o = CTRL_STALL;
      control_e_o = CTRL_STALL;
      control_m_o = CTRL_STALL;
      control_w_o = CTRL_FLUSH;
    end else if (pc_src_e_i) begin
      // Decode holds a wrong-path instruction, so its hazards are moot.
      control_d_o = CTRL_FLUSH;
      control_e_o = CTRL_FLUSH;
    end else if (w_d_stall) begin
      control_f_o = CTRL_STALL;
      control_d_o = CTRL_STALL;
      control_e_o = CTRL_FLUSH;
    end else begin
      control_f_o = CTRL_CONTINUE;
    end
  end

  // Scoreboard acceptance: a retire with nothing in flight is stale; an issue
  // is refused while memory stalls E or when it would exceed MC_DEPTH.
  always_comb begin
    w_done_acc    = mc_done_i && (r_outstanding != 3'd0);
    w_issue_acc   = mc_issue_e_i && !mem_busy_i &&
                    ((r_outstanding < MC_MAX) || w_done_acc);
    w_pending_nxt = r_pending;
    if (w_done_acc) begin
      w_pending_nxt[mc_rd_i] = 1'b0;
    end else begin
      w_pending_nxt = r_pending;
    end
    // Applied after the clear so a same-register set wins.
    if (w_issue_acc && rd_e_i != ZERO_REG) begin
      w_pending_nxt[rd_e_i] = 1'b1;
    end else begin
      w_pending_nxt[0] = 1'b0;
    end
    w_pending_nxt[0] = 1'b0;
  end

  // Scoreboard state: pending bits and outstanding-operation count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pending     <= {NREG{1'b0}};
      r_outstanding <= 3'd0;
    end else begin
      r_pending <= w_pending_nxt;
      case ({w_issue_acc, w_done_acc})
        2'b10:   r_outstanding <= r_outstanding + 3'd1;
        2'b01:   r_outstanding <= r_outstanding - 3'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= {CNT_WIDTH{1'b0}};
    end else if (w_stall_any && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_cnt_o = r_stall_cnt;

endmodule
